cordic_lut_loader: RTL and testbench

- Upstream companion of CORDIC_16_pipe.
- Copies the 64-entry, 48-bit angle/gain LUT from a synchronous ROM into the core's write port (wen / index_wri / D).
- After loading, pulses the core's active-low reset so the phase accumulator starts clean, then flags done.
- Replaces the bench-side load sequencing with synthesizable RTL.

---
 rtl/cordic_lut_loader.sv | 184 ++++++++++++++++++
 tb/tb_cordic_lut_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_lut_loader.sv
// Streams the 64-entry CORDIC angle/gain LUT from a synchronous ROM into the core's write port,
// then pulses the core reset low and raises done. Optional checksum: define LUT_CHECKSUM_EN.
module cordic_lut_loader #(
    parameter int DATA_W     = 48,
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 64,
    parameter int RST_CYCLES = 2
`ifdef LUT_CHECKSUM_EN
    ,
    parameter logic [DATA_W-1:0] EXP_SUM = '0
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              wen,
    output logic [ADDR_W-1:0] index_wri,
    output logic [DATA_W-1:0] D,
    output logic              core_reset,
    output logic              busy,
    output logic              done
`ifdef LUT_CHECKSUM_EN
    ,
    output logic              checksum_err
`endif
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_EXT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_WRITE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               wen_q, wen_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               core_reset_q, core_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic [ADDR_W:0]    addr_ahead;
    logic               accept;
`ifdef LUT_CHECKSUM_EN
    logic [DATA_W-1:0]  sum_q, sum_d;
    logic               err_q, err_d;
`endif

    // ROM runs two addresses ahead of the write index: one cycle of ROM latency plus the D register.
    always_comb begin
        addr_ahead = {1'b0, index_q} + (ADDR_W + 1)'(3);
        if (addr_ahead > LAST_EXT) begin
            addr_ahead = LAST_EXT;
        end
    end

    always_comb begin
        state_d      = state_q;
        wen_d        = 1'b1;
        index_d      = '1;
        data_d       = data_q;
        rom_addr_d   = rom_addr_q;
        core_reset_d = 1'b1;
        busy_d       = busy_q;
        done_d       = done_q;
        rel_cnt_d    = rel_cnt_q;
        accept       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                rom_addr_d = '0;
                if (start) begin
                    accept     = 1'b1;
                    state_d    = S_PRIME;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    rom_addr_d = ADDR_W'(1);
                end
            end
            S_PRIME: begin
                state_d    = S_WRITE;
                wen_d      = 1'b0;
                index_d    = '0;
                data_d     = rom_data;
                rom_addr_d = ADDR_W'(2);
            end
            S_WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d      = S_RELEASE;
                    core_reset_d = 1'b0;
                    rel_cnt_d    = '0;
                    rom_addr_d   = '0;
                end else begin
                    wen_d      = 1'b0;
                    index_d    = index_q + ADDR_W'(1);
                    data_d     = rom_data;
                    rom_addr_d = addr_ahead[ADDR_W-1:0];
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    core_reset_d = 1'b0;
                    rel_cnt_d    = rel_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef LUT_CHECKSUM_EN
    // Sums the words actually presented to the core, so it checks the ROM-to-core path end to end.
    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (accept) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (!wen_q) begin
            sum_d = sum_q + data_q;
        end
        if (state_q == S_RELEASE && state_d == S_DONE) begin
            err_d = (sum_q != EXP_SUM);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wen_q        <= 1'b1;
            index_q      <= '1;
            data_q       <= '0;
            rom_addr_q   <= '0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rel_cnt_q    <= '0;
`ifdef LUT_CHECKSUM_EN
            sum_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            index_q      <= index_d;
            data_q       <= data_d;
            rom_addr_q   <= rom_addr_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rel_cnt_q    <= rel_cnt_d;
`ifdef LUT_CHECKSUM_EN
            sum_q        <= sum_d;
            err_q        <= err_d;
`endif
        end
    end

    assign rom_addr   = rom_addr_q;
    assign wen        = wen_q;
    assign index_wri  = index_q;
    assign D          = data_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef LUT_CHECKSUM_EN
    assign checksum_err = err_q;
`endif

endmodule

// File: tb/tb_cordic_lut_loader.sv
// Bench for cordic_lut_loader: synchronous ROM model, write scoreboard and a table of
// per-cycle expectations relative to the start edge.
module tb_cordic_lut_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  rom_addr;
    logic [47:0] rom_data;
    logic        wen;
    logic [5:0]  index_wri;
    logic [47:0] D;
    logic        core_reset;
    logic        busy;
    logic        done;
`ifdef LUT_CHECKSUM_EN
    logic        checksum_err;
`endif

    cordic_lut_loader #(
        .DATA_W(48),
        .ADDR_W(6),
        .DEPTH(64),
        .RST_CYCLES(2)
`ifdef LUT_CHECKSUM_EN
        ,
        .EXP_SUM(48'h40)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .wen(wen),
        .index_wri(index_wri),
        .D(D),
        .core_reset(core_reset),
        .busy(busy),
        .done(done)
`ifdef LUT_CHECKSUM_EN
        ,
        .checksum_err(checksum_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic ones_mode;

    function automatic logic [47:0] rom_word(input logic [5:0] a);
        if (ones_mode) return 48'h1;
        return 48'h0000_0100_0000 + {42'd0, a};
    endfunction

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    typedef struct packed {
        logic [5:0]  idx;
        logic [47:0] data;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        int         n;
        logic       wen;
        logic [5:0] idx;
        logic [5:0] addr;
        logic       crst;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t tbl[10];

    int n_checks;
    int n_fail;
    int wr_cnt;
    int crst_low;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (wen === 1'b0) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_index", {58'd0, index_wri}, {58'd0, e.idx});
                check("sb_data", {16'd0, D}, {16'd0, e.data});
            end
        end
        if (core_reset === 1'b0) crst_low++;
    endtask

    task automatic do_load(input int restart_idx, input int abort_idx);
        wr_t        e;
        int         done_n;
        logic [47:0] sum;
        done_n   = -1;
        wr_cnt   = 0;
        crst_low = 0;
        sum      = '0;
        sb_q.delete();
        for (int k = 0; k < 64; k++) begin
            e.idx  = 6'(k);
            e.data = rom_word(6'(k));
            sum    = sum + e.data;
            sb_q.push_back(e);
        end
        start = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            start = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (tbl[i].n == n) begin
                    check($sformatf("vec_n%0d", n),
                          {48'd0, wen, index_wri, rom_addr, core_reset, busy, done},
                          {48'd0, tbl[i].wen, tbl[i].idx, tbl[i].addr, tbl[i].crst, tbl[i].busy, tbl[i].done});
                end
            end
`ifdef LUT_CHECKSUM_EN
            if (n == 1) check("cksum_clear_on_start", {63'd0, checksum_err}, 64'd0);
`endif
            if (abort_idx >= 0 && wen === 1'b0 && index_wri == 6'(abort_idx)) begin
                reset = 1'b0;
                tick();
                check("abort_state", {56'd0, wen, index_wri, core_reset},
                      {56'd0, 1'b1, 6'h3F, 1'b0});
                check("abort_busy_done", {62'd0, busy, done}, 64'd0);
                check("abort_wr_cnt", 64'(wr_cnt), 64'(abort_idx + 1));
                reset = 1'b1;
                sb_q.delete();
                tick();
                check("abort_no_write", 64'(wr_cnt), 64'(abort_idx + 1));
                return;
            end
            if (restart_idx >= 0 && wen === 1'b0 && index_wri == 6'(restart_idx)) start = 1'b1;
            if (done === 1'b1) begin
                done_n = n;
                break;
            end
        end
        check("done_latency", 64'(done_n), 64'd68);
        check("write_count", 64'(wr_cnt), 64'd64);
        check("release_low_cycles", 64'(crst_low), 64'd2);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("d_hold", {16'd0, D}, {16'd0, rom_word(6'd63)});
`ifdef LUT_CHECKSUM_EN
        check("checksum_err", {63'd0, checksum_err}, {63'd0, (sum != 48'h40)});
`endif
    endtask

    initial begin
        tbl[0] = '{1,  1'b1, 6'h3F, 6'd1,  1'b1, 1'b1, 1'b0};
        tbl[1] = '{2,  1'b0, 6'd0,  6'd2,  1'b1, 1'b1, 1'b0};
        tbl[2] = '{3,  1'b0, 6'd1,  6'd3,  1'b1, 1'b1, 1'b0};
        tbl[3] = '{22, 1'b0, 6'd20, 6'd22, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{63, 1'b0, 6'd61, 6'd63, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{64, 1'b0, 6'd62, 6'd63, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{65, 1'b0, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{66, 1'b1, 6'h3F, 6'd0,  1'b0, 1'b1, 1'b0};
        tbl[8] = '{67, 1'b1, 6'h3F, 6'd0,  1'b0, 1'b1, 1'b0};
        tbl[9] = '{68, 1'b1, 6'h3F, 6'd0,  1'b1, 1'b0, 1'b1};

        n_checks  = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        crst_low  = 0;
        ones_mode = 1'b0;
        reset     = 1'b0;
        start     = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", {54'd0, wen, index_wri, rom_addr, core_reset},
              {54'd0, 1'b1, 6'h3F, 6'd0, 1'b0});
        check("reset_data", {16'd0, D}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
`ifdef LUT_CHECKSUM_EN
        check("reset_cksum", {63'd0, checksum_err}, 64'd0);
`endif

        // Reset + start together: reset must win.
        start = 1'b1;
        tick();
        check("reset_beats_start", {62'd0, busy, wen}, {62'd0, 1'b0, 1'b1});
        start = 1'b0;

        reset = 1'b1;
        tick();
        check("core_reset_release", {63'd0, core_reset}, 64'd1);
        check("idle_after_reset", {62'd0, busy, done}, 64'd0);

        do_load(-1, -1);

        repeat (4) tick();
        check("done_holds", {62'd0, busy, done}, {62'd0, 1'b0, 1'b1});

        // Reload from DONE with a stray start during the write burst.
        do_load(20, -1);

        // Abort mid-load, then a full load from index 0.
        do_load(-1, 30);
        check("idle_after_abort", {62'd0, busy, done}, 64'd0);
        do_load(-1, -1);

        ones_mode = 1'b1;
        repeat (3) tick();
        do_load(-1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
